mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of EX; consumes EX_AluData (effective address), rs2 store data and IDEX_LdType/IDEX_StType via the EX/MEM register.
- Drives the D-cache request/ack handshake, generates byte enables and store-data replication, and aligns and sign-extends load data for writeback.
- Stalls the pipeline while an access is outstanding.
- Detects misaligned accesses without issuing them.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in ACCESS without Dcache_Ack before fault (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- EXMem_Valid  input  1  EX/MEM register holds a live instruction
- EXMem_AluData  input  32  effective address from EX
- EXMem_Rs2Data  input  32  store data
- EXMem_LdType  input  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6-7 reserved (treated as none)
- EXMem_StType  input  2  0 none, 1 SB, 2 SH, 3 SW
- Mem_Flush  input  1  kill the instruction in MEM
- Mem_DcacheEN  output  1  D-cache request, held until ack
- Dcache_Addr  output  32  word-aligned address {addr[31:2],2'b00}
- Dcache_WrEn  output  1  1 store, 0 load
- Dcache_ByteEn  output  4  store byte lanes
- Dcache_WrData  output  32  lane-replicated store data
- Dcache_Ack  input  1  access complete; Dcache_DataRd valid this cycle
- Dcache_DataRd  input  32  raw read word
- Mem_LdData  output  32  aligned, extended load result
- Mem_Done  output  1  one-cycle pulse: access finished, Mem_LdData valid
- Mem_Stall  output  1  freeze IF..EX/MEM
- Mem_Misalign  output  1  misaligned access, not issued

Behaviour:
- Reset: state IDLE; all outputs and latched registers 0.
- FSM states IDLE, ACCESS, DONE.
- IDLE, memory op present (EXMem_Valid, ld or st nonzero, no Mem_Flush):
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): combinational Mem_Misalign=1, Mem_Stall=0, stay IDLE, no request.
  - Otherwise: Mem_Stall=1 combinationally; latch address, offset addr[1:0], type, byte enables and data; next state ACCESS.
- ACCESS:
  - Mem_DcacheEN=1; Addr/WrEn/ByteEn/WrData come from the latched registers and stay stable; Mem_Stall=1.
  - On Dcache_Ack: register the formatted load (0 for stores) into Mem_LdData; go to DONE.
- DONE: Mem_Done=1, Mem_Stall=0, Mem_DcacheEN=0; the pipeline advances at this clock edge; always return to IDLE, never accept in DONE.
- Minimum op latency: accept cycle + 1 ACCESS cycle + DONE = 3 cycles, of which 2 are stalled.
- If both ld and st are nonzero, the load wins.
- Store formatting:
  - SB: ByteEn = 4'b0001<<off, data {4{rs2[7:0]}}.
  - SH: ByteEn = 4'b0011<<{off[1],1'b0}, data {2{rs2[15:0]}}.
  - SW: 4'b1111, rs2.
- Load formatting: select byte/half at off from Dcache_DataRd; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Flush:
  - In IDLE, Mem_Flush blocks acceptance and suppresses Mem_Misalign.
  - In ACCESS the bus transaction cannot be cancelled: keep the request until ack, then go to DONE with Mem_Done=0 and Mem_LdData unchanged. The flush is remembered in a sticky bit, set in ACCESS and cleared on DONE.
- Ack while in IDLE or DONE is ignored.
- Reset mid-ACCESS: immediate return to IDLE, request dropped.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the block goes to DONE, pulses extra output Mem_AccessFault (1 bit) together with Mem_Done, and leaves Mem_LdData unchanged.
  - An ack in the same cycle as the timeout wins.
- Undefined: no counter and no Mem_AccessFault port; ACCESS waits indefinitely.

Decomposition:
- Package mem_pkg: LdType/StType encodings, FSM state encoding, width constants.
- One sub-module, mem_ld_align: combinational byte/half select and sign/zero extension (inputs raw word, offset, ld type).

Test Plan:
- LW at 0x100, ack in first ACCESS cycle, DataRd=0xDEADBEEF -> stall high 2 cycles, Mem_Done in cycle 3, Mem_LdData=0xDEADBEEF, Dcache_Addr=0x100.
- LB at 0x103 with DataRd=0x80FF_FF_FF -> LdData=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102, DataRd=0x8001_0000 -> 0x00008001.
- SH at 0x206, rs2=0x1234ABCD -> ByteEn=4'b1100, WrData=0xABCDABCD, WrEn=1, Addr=0x204, Mem_LdData=0 at Done.
- LW at 0x101 -> Mem_Misalign=1 same cycle, Mem_DcacheEN never asserted, Stall=0.
- SW with ack delayed 5 cycles and Mem_Flush pulsed in ACCESS -> request and address stable all 5 cycles, DONE reached, Mem_Done=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> Mem_AccessFault and Mem_Done pulse after 4 ACCESS cycles, then IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: load/store types, FSM states, widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LH   = 3'd2,
    LD_LW   = 3'd3,
    LD_LBU  = 3'd4,
    LD_LHU  = 3'd5
  } ld_type_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SB   = 2'd1,
    ST_SH   = 2'd2,
    ST_SW   = 2'd3
  } st_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_e;

  // Byte lanes written by a store at byte offset off.
  function automatic logic [BE_W-1:0] store_be(input logic [1:0] st, input logic [1:0] off);
    logic [BE_W-1:0] be;
    be = '0;
    case (st)
      ST_SB:   be = 4'b0001 << off;
      ST_SH:   be = 4'b0011 << {off[1], 1'b0};
      ST_SW:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enabled lanes carry the right bytes.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] st, input logic [DATA_W-1:0] rs2);
    logic [DATA_W-1:0] d;
    d = '0;
    case (st)
      ST_SB:   d = {4{rs2[7:0]}};
      ST_SH:   d = {2{rs2[15:0]}};
      ST_SW:   d = rs2;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_ld_align.sv
// Selects the addressed byte/half of a raw read word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mem_ld_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        off,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] dat
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? raw[31:16] : raw[15:0];

  // Extend the selected field according to the load flavour; reserved types yield 0.
  always_comb begin
    dat = '0;
    case (ld_type)
      LD_LB:   dat = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  dat = {24'd0, byte_sel};
      LD_LH:   dat = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  dat = {16'd0, half_sel};
      LD_LW:   dat = raw;
      default: dat = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues D-cache accesses, formats stores, aligns loads; MEM_TIMEOUT_EN adds an ack watchdog.
// Latency: 3 cycles per access minimum (accept, >=1 ACCESS, DONE), 2 of them stalled.
// Backpressure: Mem_Stall holds IF..EX/MEM while a request is outstanding; misaligned ops are refused unstalled.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EXMem_Valid,
  input  logic [DATA_W-1:0] EXMem_AluData,
  input  logic [DATA_W-1:0] EXMem_Rs2Data,
  input  logic [2:0]        EXMem_LdType,
  input  logic [1:0]        EXMem_StType,
  input  logic              Mem_Flush,
  output logic              Mem_DcacheEN,
  output logic [DATA_W-1:0] Dcache_Addr,
  output logic              Dcache_WrEn,
  output logic [BE_W-1:0]   Dcache_ByteEn,
  output logic [DATA_W-1:0] Dcache_WrData,
  input  logic              Dcache_Ack,
  input  logic [DATA_W-1:0] Dcache_DataRd,
  output logic [DATA_W-1:0] Mem_LdData,
  output logic              Mem_Done,
  output logic              Mem_Stall,
`ifdef MEM_TIMEOUT_EN
  output logic              Mem_AccessFault,
`endif
  output logic              Mem_Misalign
);

  mem_state_e state, state_nxt;

  logic              is_ld, is_st, mem_op, misalign, accept, timeout, flush_q;
  logic [1:0]        off_q;
  logic [2:0]        ld_q;
  logic              wr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] addr_q, wdat_q, ld_fmt;

  // Decode the incoming op; a valid load type takes priority over any store type.
  always_comb begin
    is_ld    = (EXMem_LdType >= LD_LB) && (EXMem_LdType <= LD_LHU);
    is_st    = !is_ld && (EXMem_StType != ST_NONE);
    mem_op   = EXMem_Valid && (is_ld || is_st) && !Mem_Flush;
    misalign = 1'b0;
    if (is_ld) begin
      if ((EXMem_LdType == LD_LH) || (EXMem_LdType == LD_LHU)) misalign = EXMem_AluData[0];
      else if (EXMem_LdType == LD_LW)                          misalign = |EXMem_AluData[1:0];
    end else if (is_st) begin
      if (EXMem_StType == ST_SH)      misalign = EXMem_AluData[0];
      else if (EXMem_StType == ST_SW) misalign = |EXMem_AluData[1:0];
    end
    accept       = (state == S_IDLE) && mem_op && !misalign;
    Mem_Misalign = (state == S_IDLE) && mem_op && misalign;
  end

  // State register; async reset drops any outstanding request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DONE always lasts one cycle and never accepts, so back-to-back ops see a gap.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
      S_ACCESS: if (Dcache_Ack || timeout) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the request at accept so the bus sees stable values for the whole ACCESS phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      off_q  <= '0;
      ld_q   <= LD_NONE;
      wr_q   <= 1'b0;
      be_q   <= '0;
      wdat_q <= '0;
    end else if (accept) begin
      addr_q <= {EXMem_AluData[31:2], 2'b00};
      off_q  <= EXMem_AluData[1:0];
      ld_q   <= is_ld ? EXMem_LdType : LD_NONE;
      wr_q   <= !is_ld;
      be_q   <= is_ld ? '0 : store_be(EXMem_StType, EXMem_AluData[1:0]);
      wdat_q <= is_ld ? '0 : store_data(EXMem_StType, EXMem_Rs2Data);
    end
  end

  // A flush during ACCESS cannot cancel the bus cycle; remember it so DONE stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              flush_q <= 1'b0;
    else if (state == S_DONE)                flush_q <= 1'b0;
    else if (state == S_ACCESS && Mem_Flush) flush_q <= 1'b1;
  end

  mem_ld_align u_ld_align (
    .raw     (Dcache_DataRd),
    .off     (off_q),
    .ld_type (ld_q),
    .dat     (ld_fmt)
  );

  // Load result register: updated only by a live (unflushed) ack; stores report 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Mem_LdData <= '0;
    else if (state == S_ACCESS && Dcache_Ack && !flush_q && !Mem_Flush)
      Mem_LdData <= wr_q ? '0 : ld_fmt;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;

  assign timeout = (state == S_ACCESS) && !Dcache_Ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts ACCESS cycles without ack; an ack on the limit cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else if (state == S_ACCESS && !Dcache_Ack) begin
      cnt_q   <= cnt_q + 1'b1;
      fault_q <= timeout;
    end
  end

  assign Mem_AccessFault = (state == S_DONE) && fault_q;
`else
  // No watchdog in this build: ACCESS waits for ack indefinitely.
  assign timeout = 1'b0;
`endif

  assign Mem_DcacheEN  = (state == S_ACCESS);
  assign Dcache_Addr   = addr_q;
  assign Dcache_WrEn   = wr_q;
  assign Dcache_ByteEn = be_q;
  assign Dcache_WrData = wdat_q;
  assign Mem_Done      = (state == S_DONE) && !flush_q;
  assign Mem_Stall     = accept || (state == S_ACCESS);

endmodule
